// File: rtl/count_frame_sequencer.sv
// count_frame_sequencer: runs one counter-bank acquisition and streams the frame.
// Each frame goes CLEAR -> COUNT -> SNAP -> SEND. SEND streams the NWORDS
// snapshotted 10-bit words using valid/ready handshaking.
// Ports:
//   clk50, rst_n          clock, async active-low reset
//   acq_req, cont_mode    start request; auto re-arm after each frame
//   abort                 level, forces IDLE
//   stim_en / stim_cmd    test-pulser enable in / registered enable out
//   cnt_done, counts_bus  counter bank status and count words (word i at [10i+9:10i])
//   cnt_clr, cnt_start    counter bank clear / count enable
//   out_data/valid/ready/last  frame word stream
//   busy, frame_seq, err_timeout  status
module count_frame_sequencer #(
    parameter int unsigned NWORDS  = 53,
    parameter int unsigned TIMEOUT = 16'd60000
) (
    input  logic                   clk50,
    input  logic                   rst_n,
    input  logic                   acq_req,
    input  logic                   cont_mode,
    input  logic                   abort,
    input  logic                   stim_en,
    input  logic                   cnt_done,
    input  logic [10*NWORDS-1:0]   counts_bus,
    output logic                   cnt_clr,
    output logic                   cnt_start,
    output logic                   stim_cmd,
    output logic [9:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic [7:0]             frame_seq,
    output logic                   err_timeout
);

    localparam int unsigned WORD_W = 10;
    localparam int unsigned BUS_W  = WORD_W * NWORDS;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned WAIT_W = 16;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NWORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_SNAP,
        S_SEND
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BUS_W-1:0]    snap_q, snap_d;
    logic [7:0]          frame_seq_q, frame_seq_d;
    logic                err_timeout_q, err_timeout_d;
    logic                cnt_clr_q, cnt_clr_d;
    logic                cnt_start_q, cnt_start_d;
    logic                stim_cmd_q, stim_cmd_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                xfer_c;

    // State and register update
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            idx_q         <= '0;
            snap_q        <= '0;
            frame_seq_q   <= '0;
            err_timeout_q <= 1'b0;
            cnt_clr_q     <= 1'b0;
            cnt_start_q   <= 1'b0;
            stim_cmd_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            frame_seq_q   <= frame_seq_d;
            err_timeout_q <= err_timeout_d;
            cnt_clr_q     <= cnt_clr_d;
            cnt_start_q   <= cnt_start_d;
            stim_cmd_q    <= stim_cmd_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
        end
    end

    // Next state, counters and snapshot
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        frame_seq_d   = frame_seq_q;
        err_timeout_d = err_timeout_q;
        xfer_c        = out_valid_q & out_ready;

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (acq_req) begin
                        state_d       = S_CLEAR;
                        err_timeout_d = 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_d = S_COUNT;
                    wait_d  = '0;
                end
                S_COUNT: begin
                    // cnt_done wins over a timeout landing on the same cycle
                    if (cnt_done) begin
                        state_d = S_SNAP;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d       = S_IDLE;
                        err_timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_SNAP: begin
                    snap_d  = counts_bus;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    // Snapshot shifts down one word per transfer; word 0 is always the current one
                    if (xfer_c) begin
                        snap_d = snap_q >> WORD_W;
                        if (idx_q == LAST_IDX) begin
                            idx_d       = '0;
                            frame_seq_d = frame_seq_q + 8'd1;
                            state_d     = cont_mode ? S_CLEAR : S_IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs registered from the next state so they line up with state_q
        cnt_clr_d   = (state_d == S_CLEAR);
        cnt_start_d = (state_d == S_COUNT);
        out_valid_d = (state_d == S_SEND);
        out_last_d  = (state_d == S_SEND) && (idx_d == LAST_IDX);
        busy_d      = (state_d != S_IDLE);
        stim_cmd_d  = stim_en && (state_q == S_COUNT) && !abort;
    end

    assign cnt_clr     = cnt_clr_q;
    assign cnt_start   = cnt_start_q;
    assign stim_cmd    = stim_cmd_q;
    assign out_data    = snap_q[WORD_W-1:0];
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign frame_seq   = frame_seq_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_count_frame_sequencer.sv
// Bench for count_frame_sequencer: directed frame scenarios with random data,
// stall patterns and pulser enables, checked against a word-array/sequence model.
module tb_count_frame_sequencer;

    localparam int unsigned NW = 53;
    localparam int unsigned TO = 200;

    logic            clk50 = 1'b0;
    logic            rst_n;
    logic            acq_req;
    logic            cont_mode;
    logic            abort;
    logic            stim_en;
    logic            cnt_done;
    logic [10*NW-1:0] counts_bus;
    logic            cnt_clr;
    logic            cnt_start;
    logic            stim_cmd;
    logic [9:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic [7:0]      frame_seq;
    logic            err_timeout;

    int vectors     = 0;
    int miscompares = 0;
    int exp_seq     = 0;
    logic [9:0] snap_model [NW];

    always #5 clk50 = ~clk50;

    count_frame_sequencer #(.NWORDS(NW), .TIMEOUT(TO)) dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .acq_req     (acq_req),
        .cont_mode   (cont_mode),
        .abort       (abort),
        .stim_en     (stim_en),
        .cnt_done    (cnt_done),
        .counts_bus  (counts_bus),
        .cnt_clr     (cnt_clr),
        .cnt_start   (cnt_start),
        .stim_cmd    (stim_cmd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .frame_seq   (frame_seq),
        .err_timeout (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    // One frame from CLEAR (or from IDLE when pulse=1). cnt_done is raised in COUNT
    // cycle k. dmode: 0 word i = i, 1 random. rmode: 0 ready=1, 1 toggle, 2 random.
    // abort_at >= 0 aborts (with a same-cycle acq_req) while word abort_at is presented.
    task automatic do_frame(input bit pulse, input int k, input int dmode,
                            input int rmode, input bit cont, input int abort_at);
        int   starts;
        int   idx;
        int   budget;
        logic stim_prev;
        logic rdy;
        logic [9:0] w;
        cont_mode = cont;
        if (pulse) begin
            acq_req = 1'b1;
            tick();
            acq_req = 1'b0;
        end
        check("clr_pulse", 32'(cnt_clr), 32'd1);
        check("busy_clear", 32'(busy), 32'd1);
        check("start_in_clear", 32'(cnt_start), 32'd0);
        tick();
        starts    = 0;
        stim_prev = 1'b0;
        for (int c = 0; c <= k; c++) begin
            if (cnt_start) starts++;
            check("stim_lag", 32'(stim_cmd), 32'(stim_prev));
            check("valid_in_count", 32'(out_valid), 32'd0);
            stim_en   = 1'($urandom);
            stim_prev = stim_en;
            cnt_done  = (c == k);
            tick();
        end
        cnt_done = 1'b0;
        stim_en  = 1'b0;
        check("start_cycles", 32'(starts), 32'(k + 1));
        check("start_in_snap", 32'(cnt_start), 32'd0);
        check("clr_in_snap", 32'(cnt_clr), 32'd0);
        check("stim_snap", 32'(stim_prev), 32'(stim_cmd));
        check("valid_in_snap", 32'(out_valid), 32'd0);
        for (int i = 0; i < int'(NW); i++) begin
            w = (dmode == 0) ? 10'(i) : 10'($urandom);
            snap_model[i] = w;
            counts_bus[10*i +: 10] = w;
        end
        tick();
        for (int i = 0; i < int'(NW); i++) counts_bus[10*i +: 10] = 10'($urandom);
        idx    = 0;
        budget = 0;
        while (idx < int'(NW) && budget < 8 * int'(NW)) begin
            check("valid_send", 32'(out_valid), 32'd1);
            check("data", 32'(out_data), 32'(snap_model[idx]));
            check("last", 32'(out_last), 32'(idx == int'(NW) - 1));
            check("stim_send", 32'(stim_cmd), 32'd0);
            if (idx == abort_at) begin
                abort   = 1'b1;
                acq_req = 1'b1;
                tick();
                abort   = 1'b0;
                acq_req = 1'b0;
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_seq", 32'(frame_seq), 32'(exp_seq));
                check("abort_clr", 32'(cnt_clr), 32'd0);
                tick();
                check("abort_acq_ignored", 32'(busy), 32'd0);
                return;
            end
            case (rmode)
                1:       rdy = (budget % 2) == 0;
                2:       rdy = 1'($urandom);
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            tick();
            if (rdy) idx++;
            budget++;
        end
        out_ready = 1'b1;
        check("words_sent", 32'(idx), 32'(NW));
        exp_seq = (exp_seq + 1) % 256;
        check("frame_seq", 32'(frame_seq), 32'(exp_seq));
        check("valid_after", 32'(out_valid), 32'd0);
        check("rearm_clr", 32'(cnt_clr), 32'(cont));
        check("rearm_busy", 32'(busy), 32'(cont));
    endtask

    initial begin
        int  starts;
        bit  valid_seen;
        int  frames;
        rst_n      = 1'b0;
        acq_req    = 1'b0;
        cont_mode  = 1'b0;
        abort      = 1'b0;
        stim_en    = 1'b0;
        cnt_done   = 1'b0;
        counts_bus = '0;
        out_ready  = 1'b1;

        // Reset state
        #12;
        check("rst_clr", 32'(cnt_clr), 32'd0);
        check("rst_start", 32'(cnt_start), 32'd0);
        check("rst_stim", 32'(stim_cmd), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_seq", 32'(frame_seq), 32'd0);
        @(negedge clk50);
        rst_n = 1'b1;
        tick();
        check("idle_after_rst", 32'(busy), 32'd0);

        // Basic frame: done at COUNT cycle 100, word i = i, back-to-back
        do_frame(1'b1, 100, 0, 0, 1'b0, -1);
        // Toggling ready, random data changed after SNAP
        do_frame(1'b1, $urandom_range(0, 30), 1, 1, 1'b0, -1);
        // Random stalls
        do_frame(1'b1, $urandom_range(0, 30), 1, 2, 1'b0, -1);

        // Timeout: cnt_done never arrives
        acq_req = 1'b1;
        tick();
        acq_req = 1'b0;
        check("to_clr", 32'(cnt_clr), 32'd1);
        tick();
        starts     = 0;
        valid_seen = 1'b0;
        for (int c = 0; c < int'(TO) + 10; c++) begin
            if (cnt_start) starts++;
            if (out_valid) valid_seen = 1'b1;
            tick();
        end
        check("to_start_cycles", 32'(starts), 32'(TO));
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_no_valid", 32'(valid_seen), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        check("to_seq", 32'(frame_seq), 32'(exp_seq));
        acq_req = 1'b1;
        tick();
        acq_req = 1'b0;
        check("to_err_cleared", 32'(err_timeout), 32'd0);
        do_frame(1'b0, $urandom_range(0, 20), 1, 0, 1'b0, -1);

        // Continuous mode, three frames, no IDLE between
        do_frame(1'b1, $urandom_range(0, 10), 1, 2, 1'b1, -1);
        do_frame(1'b0, $urandom_range(0, 10), 1, 0, 1'b1, -1);
        do_frame(1'b0, $urandom_range(0, 10), 1, 1, 1'b0, -1);

        // Abort at word 20 with acq_req in the same cycle
        do_frame(1'b1, $urandom_range(0, 10), 0, 0, 1'b0, 20);

        // Reset mid-COUNT with stim_en high
        acq_req = 1'b1;
        tick();
        acq_req = 1'b0;
        tick();
        stim_en = 1'b1;
        tick();
        tick();
        check("pre_rst_stim", 32'(stim_cmd), 32'd1);
        check("pre_rst_start", 32'(cnt_start), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_stim", 32'(stim_cmd), 32'd0);
        check("async_start", 32'(cnt_start), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_seq", 32'(frame_seq), 32'd0);
        exp_seq = 0;
        stim_en = 1'b0;
        @(negedge clk50);
        rst_n = 1'b1;
        tick();
        check("idle_after_rel", 32'(busy), 32'd0);
        check("clr_after_rel", 32'(cnt_clr), 32'd0);

        // 256 continuous frames: frame_seq wraps to 0
        frames = 0;
        do_frame(1'b1, $urandom_range(0, 3), 1, 0, 1'b1, -1);
        frames++;
        while (frames < 256) begin
            do_frame(1'b0, $urandom_range(0, 3), 1, 0, frames != 255, -1);
            frames++;
        end
        check("seq_wrap", 32'(frame_seq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
